lm_frame_packer: RTL and testbench
==================================

// Module: lm_frame_packer
// PURPOSE
//  Upstream feeder for the lane-array consumer stage. Collects a stream of 5-bit symbols.
//  Packs them into one 80-bit frame typed [1:4][3:0][0:4] (4 lanes x 4 slots x 5 bits).
//  Each frame carries a 12-bit per-lane tag word typed [0:3][2:0].
//  Delivers frames over a valid/ready port, so the consumer's lm/vjftkf inputs are driven at full width.
//  No implicit width conversion at that boundary.
// PARAMETERS
//  SYM_W      5    symbol width; must equal the frame's innermost dimension
//  SLOTS      4    symbols per lane
//  LANES      4    lanes per frame
//  TAG_W      3    per-lane tag width; must hold 0..SLOTS
//  CNT_W      16   width of frames_sent counter
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      symbol present
//  in_ready    out  1      packer accepts symbol this cycle
//  in_sym      in   5      symbol payload
//  in_flush    in   1      close current frame (see BEHAVIOUR)
//  out_valid   out  1      frame present on out_lm/out_tag
//  out_ready   in   1      consumer takes frame this cycle
//  out_lm      out  80     packed frame [1:4][3:0][0:4]
//  out_tag     out  12     per-lane valid-symbol count [0:3][2:0]
//  frames_sent out  CNT_W  frames handed off, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - out_valid=0, out_lm=0, out_tag=0, frames_sent=0, fill count=0, state=FILL.
//   - in_ready=0 while rst is high.
//  Symbol acceptance
//   - A symbol is accepted when in_valid & in_ready.
//   - Symbol k (0..15) of a frame is written to lane 1+k/4, slot 3-(k%4): the first symbol lands at [1][3].
//  Fill state machine
//   - FILL: count 0..15.
//     - Accepting the 16th symbol closes the frame.
//     - Accepting any symbol with in_flush=1 closes the frame.
//     - in_flush with in_valid=0 and count>0 closes the partial frame.
//     - in_flush with count==0 and no symbol accepted is ignored.
//   - On close, if the output slot is free or draining this cycle (out_valid=0 | out_ready=1):
//     - frame moves to the slot at the next edge;
//     - count returns to 0; state stays FILL.
//   - On close otherwise, state goes to FULL.
//   - FULL: in_ready=0. Transfers to the slot in the first cycle out_ready=1 (the old frame drains that same cycle), then returns to FILL.
//  in_ready
//   - in_ready = !rst & (state==FILL).
//   - Deasserts only in FULL; no combinational path from out_ready to in_ready.
//  Padding and tags
//   - Unfilled slots are 0.
//   - out_tag[i] = number of valid symbols in lane i+1 (0..4).
//   - Tags of lanes after the last filled lane are 0.
//  Output slot
//   - out_valid rises the cycle after transfer: latency is 1 clk from the closing symbol to out_valid.
//   - out_lm/out_tag hold stable while out_valid & !out_ready.
//   - The slot clears on handoff unless it is refilled in the same cycle.
//   - Back-to-back frames are sustained at 1 symbol/clk with no bubble when out_ready=1.
//  frames_sent: increments on each out_valid & out_ready; 2^CNT_W-1 wraps to 0.
//  Reset mid-operation
//   - Partial fill, FULL frame and slot contents are discarded.
//   - No spurious out_valid after release.
// STRUCTURE
//  lmpack_pkg
//   - Typedefs: lm_frame_t = logic [1:4][3:0][0:4]; lane_tag_t = logic [0:3][2:0]; enum fill_state_t {FILL, FULL}.
//   - Constants: SYMS_PER_FRAME=16 and slot-index helper function.
//  lmpack_out_slot
//   - One sub-module: single-entry valid/ready register holding lm_frame_t + lane_tag_t.
//   - Transfer-while-drain supported.
//  Top holds fill buffer, counter, FSM, tag computation.
// TESTING
//  1 Reset: rst pulsed mid-clock, no clk -> out_valid=0, in_ready=0 immediately; after release in_ready=1, frames_sent=0.
//  2 Full frame: 16 syms 5'h01..5'h10, out_ready=1 ->
//    - out_valid one clk after sym 16; out_lm[1][3]=5'h01, out_lm[4][0]=5'h10;
//    - out_tag=12'o4444; frames_sent=1.
//  3 Partial flush: 6 syms then in_flush alone ->
//    - out_tag lanes = {4,2,0,0}; out_lm[2][1:0]=0, lanes 3-4 all 0.
//  4 Backpressure: out_ready=0, feed 32 syms ->
//    - frame A held stable; frame B reaches FULL, in_ready=0 after sym 32;
//    - out_ready=1 -> A then B handed off on consecutive cycles; in_ready=1 again.
//  5 Streaming: 64 syms continuous, out_ready=1 -> in_ready never drops; 4 frames; frames_sent=4.
//  6 Edge cases:
//    - flush with count==0 -> no frame;
//    - reset while FULL -> no out_valid after release;
//    - frames_sent preloaded near 2^16-1 -> wraps to 0.

Source files
------------

// File: rtl/lmpack_pkg.sv
// lmpack_pkg
// Shared types and helpers for the lane-array frame packer.
//   lm_frame_t   : 4 lanes x 4 slots x 5-bit symbols, lanes numbered 1..4,
//                  slots numbered 3 down to 0 (slot 3 is filled first).
//   lane_tag_t   : one 3-bit valid-symbol count per lane, lanes 0..3.
//   fill_state_t : FILL while the packer accepts symbols, FULL while a closed
//                  frame waits for the output slot.
package lmpack_pkg;

    localparam int SYM_W          = 5;
    localparam int SLOTS          = 4;
    localparam int LANES          = 4;
    localparam int TAG_W          = 3;
    localparam int SYMS_PER_FRAME = SLOTS * LANES;

    typedef logic [1:4][3:0][0:4] lm_frame_t;
    typedef logic [0:3][2:0]      lane_tag_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

    // Arrival order of the symbol that belongs at [lane][slot]: lane 1 fills
    // first, and within a lane the highest slot index fills first.
    function automatic logic [3:0] symIndex(input int lane, input int slot);
        return 4'((lane - 1) * SLOTS + (SLOTS - 1 - slot));
    endfunction

    // Per-lane valid-symbol counts for a frame holding n symbols: every lane
    // before the last filled one is full, lanes after it report zero.
    function automatic lane_tag_t laneTags(input logic [4:0] n);
        lane_tag_t tags;
        int        rem;
        tags = '0;
        for (int i = 0; i < LANES; i++) begin
            rem = int'(n) - SLOTS * i;
            if (rem >= SLOTS) begin
                tags[i] = 3'(SLOTS);
            end else if (rem > 0) begin
                tags[i] = 3'(rem);
            end else begin
                tags[i] = 3'd0;
            end
        end
        return tags;
    endfunction

endpackage

// File: rtl/lmpack_out_slot.sv
// lmpack_out_slot
// Single-entry valid/ready output register for packed frames. A new frame may
// be loaded in the same cycle the current one is taken, which is what lets the
// packer stream one frame every 16 clocks with no bubble.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   load_i        capture frame_i/tag_i at the next edge (caller guarantees
//                 the slot is empty or draining this cycle)
//   frame_i/tag_i frame and per-lane tags to capture
//   ready_i       consumer takes the held frame this cycle
//   valid_o       a frame is held
//   frame_o/tag_o held frame and tags (zero when empty)
module lmpack_out_slot
    import lmpack_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_i,
    input  lm_frame_t frame_i,
    input  lane_tag_t tag_i,
    input  logic      ready_i,
    output logic      valid_o,
    output lm_frame_t frame_o,
    output lane_tag_t tag_o
);

    logic      valid_q, valid_d;
    lm_frame_t frame_q, frame_d;
    lane_tag_t tag_q,   tag_d;

    // Loading wins over draining so a transfer-while-drain keeps the slot
    // full; a plain handoff empties it and zeroes the payload.
    always_comb begin
        valid_d = valid_q;
        frame_d = frame_q;
        tag_d   = tag_q;
        if (load_i) begin
            valid_d = 1'b1;
            frame_d = frame_i;
            tag_d   = tag_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            frame_d = '0;
            tag_d   = '0;
        end
    end

    // Slot register; reset discards whatever frame was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            frame_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            frame_q <= frame_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign frame_o = frame_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/lm_frame_packer.sv
// lm_frame_packer
// Collects 5-bit symbols into 80-bit lane frames with per-lane tag words and
// hands them to the lane-array consumer over a valid/ready port.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   in_valid/in_ready symbol handshake; in_ready drops only while FULL
//   in_sym            symbol payload
//   in_flush          close the current (possibly partial) frame
//   out_valid/ready   frame handshake
//   out_lm            packed frame [1:4][3:0][0:4]
//   out_tag           per-lane valid-symbol counts [0:3][2:0]
//   frames_sent       handed-off frame count, wraps modulo 2^CNT_W
module lm_frame_packer
    import lmpack_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_sym,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output lm_frame_t        out_lm,
    output lane_tag_t        out_tag,
    output logic [CNT_W-1:0] frames_sent
);

    fill_state_t      state_q, state_d;
    lm_frame_t        fill_buf_q, fill_buf_d;
    lm_frame_t        frame_wr, load_frame;
    lane_tag_t        load_tag;
    logic [4:0]       count_q, count_d, count_inc;
    logic             accept, close_fill, slot_free, slot_load;
    logic [CNT_W-1:0] frames_sent_q;

    // count_q runs 0..15 while filling and holds 1..16 while FULL, so it
    // needs one bit more than a symbol index.
    assign in_ready   = !rst && (state_q == FILL);
    assign accept     = in_valid && in_ready;
    assign count_inc  = count_q + {4'd0, accept};
    assign slot_free  = !out_valid || out_ready;
    assign close_fill = (state_q == FILL) &&
                        ((count_inc == 5'(SYMS_PER_FRAME)) ||
                         (in_flush && (accept || (count_q != 5'd0))));

    // Fill buffer with this cycle's symbol merged in, so a closing symbol
    // travels with its own frame.
    always_comb begin
        frame_wr = fill_buf_q;
        for (int l = 1; l <= LANES; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (accept && (count_q[3:0] == symIndex(l, s))) begin
                    frame_wr[l][s] = in_sym;
                end
            end
        end
    end

    // Fill FSM: a closed frame goes straight to the output slot when it is
    // free or draining, otherwise it parks in the fill buffer (FULL) until
    // the consumer takes the old frame.
    always_comb begin
        state_d    = state_q;
        fill_buf_d = fill_buf_q;
        count_d    = count_q;
        slot_load  = 1'b0;
        load_frame = frame_wr;
        load_tag   = laneTags(count_inc);
        case (state_q)
            FILL: begin
                if (close_fill && slot_free) begin
                    slot_load  = 1'b1;
                    fill_buf_d = '0;
                    count_d    = 5'd0;
                end else if (close_fill) begin
                    fill_buf_d = frame_wr;
                    count_d    = count_inc;
                    state_d    = FULL;
                end else begin
                    fill_buf_d = frame_wr;
                    count_d    = count_inc;
                end
            end
            FULL: begin
                load_frame = fill_buf_q;
                load_tag   = laneTags(count_q);
                if (slot_free) begin
                    slot_load  = 1'b1;
                    fill_buf_d = '0;
                    count_d    = 5'd0;
                    state_d    = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Fill-side state registers; reset drops any partial or parked frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            fill_buf_q <= '0;
            count_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            fill_buf_q <= fill_buf_d;
            count_q    <= count_d;
        end
    end

    // Handoff counter, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_sent_q <= '0;
        end else if (out_valid && out_ready) begin
            frames_sent_q <= frames_sent_q + CNT_W'(1);
        end
    end

    assign frames_sent = frames_sent_q;

    lmpack_out_slot u_out_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (slot_load),
        .frame_i (load_frame),
        .tag_i   (load_tag),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .frame_o (out_lm),
        .tag_o   (out_tag)
    );

endmodule

// File: tb/tb_lm_frame_packer.sv
// Directed bench for lm_frame_packer. A second instance with a 3-bit frame
// counter shares all inputs so counter wrap shows up within a few frames.
module tb_lm_frame_packer;
    import lmpack_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_sym;
    logic        in_flush;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    lm_frame_t   out_lm;
    lane_tag_t   out_tag;
    logic [15:0] frames_sent;

    logic        w_in_ready;
    logic        w_out_valid;
    lm_frame_t   w_out_lm;
    lane_tag_t   w_out_tag;
    logic [2:0]  w_frames_sent;

    int vectors;
    int miscompares;

    lm_frame_packer #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sym      (in_sym),
        .in_flush    (in_flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lm      (out_lm),
        .out_tag     (out_tag),
        .frames_sent (frames_sent)
    );

    lm_frame_packer #(.CNT_W(3)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (w_in_ready),
        .in_sym      (in_sym),
        .in_flush    (in_flush),
        .out_valid   (w_out_valid),
        .out_ready   (out_ready),
        .out_lm      (w_out_lm),
        .out_tag     (w_out_tag),
        .frames_sent (w_frames_sent)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 2 ms");
        $fatal(1, "[TB] timeout");
    end

    // Frame holding n symbols valued base, base+1, ... in arrival order:
    // lane 1 slot 3 first, lane 4 slot 0 last.
    function automatic lm_frame_t expFrame(input int base, input int n);
        lm_frame_t f;
        int        k;
        f = '0;
        k = 0;
        for (int l = 1; l <= 4; l++) begin
            for (int s = 3; s >= 0; s--) begin
                if (k < n) f[l][s] = 5'(base + k);
                k++;
            end
        end
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        in_valid = 1'b0;
        in_flush = 1'b0;
        rst      = 1'b1;
        #2;
        rst      = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready_hi: got %b expected 0", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || frames_sent !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got in_ready=%b frames=%0d expected 1/0", in_ready, frames_sent);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sym    = 5'h1F;
        in_flush  = 1'b1;
        step();
        in_valid  = 1'b0;
        in_flush  = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_frame: got out_valid=%b expected 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_lm !== '0 || out_tag !== '0) begin
            miscompares++;
            $display("[TB] FAIL midclock_reset: got valid=%b ready=%b lm=%h tag=%o expected 0/0/0/0",
                     out_valid, in_ready, out_lm, out_tag);
        end
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || frames_sent !== 16'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL after_release: got ready=%b frames=%0d valid=%b expected 1/0/0",
                     in_ready, frames_sent, out_valid);
        end
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_sym   = 5'(k + 1);
            step();
            if (k == 14) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL full_early_valid: got %b expected 0", out_valid);
                end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_latency: got out_valid=%b expected 1", out_valid);
        end
        vectors++;
        if (out_lm[1][3] !== 5'h01 || out_lm[4][0] !== 5'h10) begin
            miscompares++;
            $display("[TB] FAIL full_corners: got %h/%h expected 01/10", out_lm[1][3], out_lm[4][0]);
        end
        vectors++;
        if (out_lm !== expFrame(1, 16)) begin
            miscompares++;
            $display("[TB] FAIL full_frame: got %h expected %h", out_lm, expFrame(1, 16));
        end
        vectors++;
        if (out_tag !== 12'o4444) begin
            miscompares++;
            $display("[TB] FAIL full_tag: got %o expected 4444", out_tag);
        end
        step();
        vectors++;
        if (frames_sent !== 16'd1 || out_valid !== 1'b0 || out_lm !== '0) begin
            miscompares++;
            $display("[TB] FAIL full_handoff: got frames=%0d valid=%b lm=%h expected 1/0/0",
                     frames_sent, out_valid, out_lm);
        end
    endtask

    task automatic test_partial_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_sym   = 5'(16'h11 + k);
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL partial_no_close: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_tag !== 12'o4200) begin
            miscompares++;
            $display("[TB] FAIL partial_tag: got valid=%b tag=%o expected 1/4200", out_valid, out_tag);
        end
        vectors++;
        if (out_lm[2][1:0] !== 10'd0 || out_lm[3] !== 20'd0 || out_lm[4] !== 20'd0) begin
            miscompares++;
            $display("[TB] FAIL partial_pad: got lm=%h expected zero padding", out_lm);
        end
        vectors++;
        if (out_lm !== expFrame(16'h11, 6)) begin
            miscompares++;
            $display("[TB] FAIL partial_frame: got %h expected %h", out_lm, expFrame(16'h11, 6));
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (frames_sent !== 16'd2 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL partial_handoff: got frames=%0d valid=%b expected 2/0", frames_sent, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            in_valid = 1'b1;
            in_sym   = 5'(k);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL bp_in_ready_k%0d: got %b expected 1", k, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_full: got in_ready=%b expected 0", in_ready);
        end
        repeat (3) step();
        vectors++;
        if (out_valid !== 1'b1 || out_lm !== expFrame(0, 16) || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_hold_a: got valid=%b lm=%h ready=%b expected 1/%h/0",
                     out_valid, out_lm, in_ready, expFrame(0, 16));
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_lm !== expFrame(16, 16) || out_tag !== 12'o4444) begin
            miscompares++;
            $display("[TB] FAIL bp_frame_b: got valid=%b lm=%h tag=%o expected 1/%h/4444",
                     out_valid, out_lm, out_tag, expFrame(16, 16));
        end
        vectors++;
        if (in_ready !== 1'b1 || frames_sent !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL bp_a_sent: got ready=%b frames=%0d expected 1/3", in_ready, frames_sent);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || frames_sent !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL bp_b_sent: got valid=%b frames=%0d expected 0/4", out_valid, frames_sent);
        end
    endtask

    task automatic test_streaming();
        int seen;
        seen = 0;
        pulseReset();
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            in_valid = 1'b1;
            in_sym   = 5'(k + 3);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stream_in_ready_k%0d: got %b expected 1", k, in_ready);
            end
            step();
            if (out_valid === 1'b1) seen++;
            if (k == 31) begin
                vectors++;
                if (out_lm !== expFrame(19, 16)) begin
                    miscompares++;
                    $display("[TB] FAIL stream_frame2: got %h expected %h", out_lm, expFrame(19, 16));
                end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (seen != 4) begin
            miscompares++;
            $display("[TB] FAIL stream_count: got %0d frames expected 4", seen);
        end
        step();
        vectors++;
        if (frames_sent !== 16'd4 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stream_sent: got frames=%0d valid=%b expected 4/0", frames_sent, out_valid);
        end
    endtask

    task automatic test_edge_cases();
        // Flush with an empty fill buffer produces nothing.
        out_ready = 1'b1;
        in_flush  = 1'b1;
        step();
        in_flush  = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL empty_flush: got out_valid=%b expected 0", out_valid);
        end
        step();
        vectors++;
        if (frames_sent !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL empty_flush_count: got %0d expected 4", frames_sent);
        end

        // Reset while FULL discards both frames.
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            in_valid = 1'b1;
            in_sym   = 5'(k + 9);
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_full: got ready=%b valid=%b expected 0/1", in_ready, out_valid);
        end
        pulseReset();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || frames_sent !== 16'd0) begin
                miscompares++;
                $display("[TB] FAIL full_reset_c%0d: got valid=%b ready=%b frames=%0d expected 0/1/0",
                         c, out_valid, in_ready, frames_sent);
            end
        end

        // One-symbol frames back to back; the 3-bit counter wraps after 8.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_flush = 1'b1;
            in_sym   = 5'(i + 1);
            step();
            if (i == 0) begin
                vectors++;
                if (out_tag !== 12'o1000 || out_lm !== expFrame(1, 1)) begin
                    miscompares++;
                    $display("[TB] FAIL single_sym: got tag=%o lm=%h expected 1000/%h",
                             out_tag, out_lm, expFrame(1, 1));
                end
            end
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
        vectors++;
        if (frames_sent !== 16'd7 || w_frames_sent !== 3'd7) begin
            miscompares++;
            $display("[TB] FAIL pre_wrap: got %0d/%0d expected 7/7", frames_sent, w_frames_sent);
        end
        step();
        vectors++;
        if (frames_sent !== 16'd8 || w_frames_sent !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap: got %0d/%0d expected 8/0", frames_sent, w_frames_sent);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sym      = 5'd0;
        in_flush    = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_full_frame();
        test_partial_flush();
        test_backpressure();
        test_streaming();
        test_edge_cases();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
